// File: rtl/bin2bcd_seq_pkg.sv
// Shared display package for the sequential binary-to-BCD converter:
// FSM states, digit geometry and the double-dabble adjust constants.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_OFFSET = 4'd3;

  // Decimal digits in 2**w_in - 1, i.e. ceil(w_in * log10(2)).
  function automatic int unsigned min_bcd_digits(input int unsigned w_in);
    return (w_in * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb q = (d >= ADJ_THRESH) ? d + ADJ_OFFSET : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one shift-and-add-3 step per clock.
// Define BIN2BCD_SIGNED_EN to treat i_bin as two's complement and report o_neg.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned W_IN  = 16,
  parameter int unsigned N_DIG = 5
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_start,
  input  logic [W_IN-1:0]          i_bin,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [BCD_W*N_DIG-1:0]   o_bcd,
  output logic                     o_neg,
  output logic                     o_ovf
);

  localparam int unsigned DW = BCD_W * N_DIG;
  localparam int unsigned CW = $clog2(W_IN + 1);

  state_t          state;
  logic [W_IN-1:0] shift_reg;
  logic [W_IN-1:0] mag;
  logic [DW-1:0]   digits;
  logic [DW-1:0]   adj;
  logic [CW-1:0]   cnt;
  logic            ovf_acc;

  if (N_DIG < min_bcd_digits(W_IN)) begin : g_short_digits
    $info("bin2bcd_seq: N_DIG too small for W_IN, large values will set o_ovf");
  end

  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d (digits[g*BCD_W +: BCD_W]),
      .q (adj[g*BCD_W +: BCD_W])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  logic neg_cap;

  // Negation in W_IN bits maps the most negative value onto its exact magnitude.
  always_comb mag = i_bin[W_IN-1] ? ('0 - i_bin) : i_bin;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      neg_cap <= 1'b0;
      o_neg   <= 1'b0;
    end else if (state == IDLE && i_start) begin
      neg_cap <= i_bin[W_IN-1];
    end else if (state == DONE) begin
      o_neg   <= neg_cap;
    end
  end
`else
  always_comb mag = i_bin;
  assign o_neg = 1'b0;
`endif

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      digits    <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      o_done    <= 1'b0;
      o_bcd     <= '0;
      o_ovf     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            shift_reg <= mag;
            digits    <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= CW'(W_IN);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjusted digits shift as one register with the operand; the bit
          // falling off the top digit is a lost multiple of 10**N_DIG.
          {digits, shift_reg} <= {adj[DW-2:0], shift_reg, 1'b0};
          ovf_acc             <= ovf_acc | adj[DW-1];
          cnt                 <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          o_bcd  <= digits;
          o_ovf  <= ovf_acc;
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 16-bit/5-digit and an 8-bit/2-digit instance.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        s16, s8;
  logic [15:0] b16;
  logic [7:0]  b8;
  logic        busy16, done16, neg16, ovf16;
  logic [19:0] bcd16;
  logic        busy8, done8, neg8, ovf8;
  logic [7:0]  bcd8;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W_IN(16), .N_DIG(5)) dut16 (
    .i_CLK(clk), .i_RST(rst), .i_start(s16), .i_bin(b16),
    .o_busy(busy16), .o_done(done16), .o_bcd(bcd16), .o_neg(neg16), .o_ovf(ovf16)
  );

  bin2bcd_seq #(.W_IN(8), .N_DIG(2)) dut8 (
    .i_CLK(clk), .i_RST(rst), .i_start(s8), .i_bin(b8),
    .o_busy(busy8), .o_done(done8), .o_bcd(bcd8), .o_neg(neg8), .o_ovf(ovf8)
  );

`ifdef BIN2BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    logic        neg;
    int          due;
    string       name;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per o_done and checks value and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done16 === 1'b1) begin
        if (q16.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done16: got o_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q16.pop_front();
          check({e.name, "_bcd"}, 32'(bcd16), 32'(e.bcd));
          check({e.name, "_ovf"}, 32'(ovf16), 32'(e.ovf));
          check({e.name, "_neg"}, 32'(neg16), 32'(e.neg));
          check({e.name, "_cycle"}, cyc, e.due);
        end
      end
      if (done8 === 1'b1) begin
        if (q8.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done8: got o_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q8.pop_front();
          check({e.name, "_bcd"}, 32'(bcd8), 32'(e.bcd));
          check({e.name, "_ovf"}, 32'(ovf8), 32'(e.ovf));
          check({e.name, "_neg"}, 32'(neg8), 32'(e.neg));
          check({e.name, "_cycle"}, cyc, e.due);
        end
      end
    end
  end

  task automatic push16(input logic [19:0] eb, input logic eo, input logic en,
                        input int due, input string nm);
    exp_t e;
    e.bcd = eb; e.ovf = eo; e.neg = en; e.due = due; e.name = nm;
    q16.push_back(e);
  endtask

  task automatic issue16(input logic [15:0] v, input logic [19:0] eb, input logic eo,
                         input logic en, input string nm);
    @(negedge clk);
    b16 = v; s16 = 1'b1;
    push16(eb, eo, en, cyc + 18, nm);
    @(negedge clk);
    s16 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] v, input logic [7:0] eb, input logic eo,
                        input logic en, input string nm);
    exp_t e;
    @(negedge clk);
    b8 = v; s8 = 1'b1;
    e.bcd = {12'h0, eb}; e.ovf = eo; e.neg = en; e.due = cyc + 10; e.name = nm;
    q8.push_back(e);
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy16 || busy8 || q16.size() != 0 || q8.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", nm, n);
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; s16 = 1'b0; s8 = 1'b0; b16 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy16", 32'(busy16), 0);
    check("rst_done16", 32'(done16), 0);
    check("rst_bcd16",  32'(bcd16),  0);
    check("rst_ovf16",  32'(ovf16),  0);
    check("rst_neg16",  32'(neg16),  0);
    check("rst_busy8",  32'(busy8),  0);
    check("rst_bcd8",   32'(bcd8),   0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion and busy window.
    issue16(16'd12345, 20'h12345, 1'b0, 1'b0, "v12345");
    for (int i = 0; i < 17; i++) begin
      check("busy_window", 32'(busy16), 1);
      @(negedge clk);
    end
    check("busy_on_done", 32'(busy16), 0);
    check("done_pulse",   32'(done16), 1);
    wait_idle("t1");

    // Back-to-back with i_start held high.
    @(negedge clk);
    c = cyc;
    b16 = 16'd0; s16 = 1'b1;
    push16(20'h00000, 1'b0, 1'b0, c + 18, "held0");
    push16(SGN ? 20'h00001 : 20'h65535, 1'b0, SGN, c + 36, "held65535");
    @(negedge clk);
    b16 = 16'hFFFF;
    while (cyc < c + 19) @(negedge clk);
    s16 = 1'b0;
    wait_idle("t2");

    issue16(16'h8000, 20'h32768, 1'b0, SGN,  "v8000");
    wait_idle("t3a");
    issue16(16'h7FFF, 20'h32767, 1'b0, 1'b0, "v7fff");
    wait_idle("t3b");

    // Narrow instance: overflow wraps modulo 100.
    issue8(8'd255, SGN ? 8'h01 : 8'h55, ~SGN, SGN, "n255");
    wait_idle("t4a");
    issue8(8'd99,  8'h99, 1'b0, 1'b0, "n99");
    wait_idle("t4b");
    issue8(8'd128, 8'h28, 1'b1, SGN, "n128");
    wait_idle("t4c");
    issue8(8'd200, SGN ? 8'h56 : 8'h00, ~SGN, SGN, "n200");
    wait_idle("t4d");

    // Second start while busy is ignored.
    issue16(16'd1234, 20'h01234, 1'b0, 1'b0, "v1234");
    repeat (4) @(negedge clk);
    b16 = 16'd9999; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    wait_idle("t5");
    repeat (25) @(negedge clk);

    // Reset mid-conversion aborts with no o_done.
    @(negedge clk);
    b16 = 16'd1111; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy16), 0);
    check("abort_done", 32'(done16), 0);
    check("abort_bcd",  32'(bcd16),  0);
    check("abort_ovf",  32'(ovf16),  0);
    check("abort_neg",  32'(neg16),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_idle", 32'(busy16), 0);
    issue16(16'd42, 20'h00042, 1'b0, 1'b0, "v42");
    wait_idle("t6");

    repeat (3) @(negedge clk);
    check("q16_drained", q16.size(), 0);
    check("q8_drained",  q8.size(),  0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 7-segment digit decoders. Each output nibble is a decimal digit 0..9, so o_bcd[7:0] drives one two-digit decode pair directly.
- Converts measured quantities (frequency, phase, duty counters) for display on the board's 7-segment bank.

Parameters:
- W_IN, 16, binary input width (≥2).
- N_DIG, 5, number of BCD digits produced. Any value ≥1 is legal; too few digits are flagged via o_ovf.

Ports:
- i_CLK  in  1  system clock, rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_bin  in  W_IN  binary value to convert; captured on the accepted start.
- o_busy  out  1  high while a conversion is in progress (SHIFT or DONE).
- o_done  out  1  one-cycle pulse; o_bcd, o_neg and o_ovf are valid and newly updated.
- o_bcd  out  4*N_DIG  packed BCD result, digit 0 in [3:0]; held until the next o_done.
- o_neg  out  1  result sign (only meaningful with the optional feature).
- o_ovf  out  1  value ≥ 10^N_DIG; o_bcd then holds the value mod 10^N_DIG.

Behaviour:
- Reset is asynchronous and active-high.
  - While i_RST=1: state=IDLE; o_busy=0, o_done=0, o_bcd=0, o_neg=0, o_ovf=0; shift register, digit register and counter all cleared.
  - Reset asserted mid-conversion aborts it. No o_done is produced and o_bcd returns to 0.
- IDLE
  - If i_start=1 at edge k: capture the operand (magnitude, see Optional Feature) into the shift register, clear the digit register and the sticky ovf, set cnt=W_IN, go to SHIFT.
  - o_busy=1 from edge k onward.
- SHIFT, one iteration per cycle:
  - Every digit ≥5 gets +3 (4-bit, no carry between digits).
  - Then the concatenation {digits, shift_reg} shifts left by 1.
  - The bit leaving the top digit is ORed into the sticky ovf.
  - cnt decrements. When the cycle that consumes the last bit completes (edge k+W_IN), go to DONE.
- DONE (edge k+W_IN+1):
  - Register the digits into o_bcd, plus o_neg and o_ovf.
  - o_done=1 for exactly one cycle; o_busy=0 the same cycle; next state IDLE.
- Latency: o_done is high in the cycle following edge k+W_IN+1 (17 cycles after start for W_IN=16).
- Throughput: one conversion per W_IN+2 cycles.
  - i_start is ignored while o_busy=1, including during the DONE cycle.
  - i_start held high re-triggers on the first IDLE cycle.
- i_bin changes after capture have no effect.
- The digit adjust runs every SHIFT cycle, including the first (all-zero digits, so no change).
- o_ovf is independent of o_neg.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined: i_bin is two's complement.
  - At capture, the magnitude is formed as (i_bin[W_IN-1] ? -i_bin : i_bin), computed in W_IN bits unsigned.
  - -2^(W_IN-1) therefore yields 2^(W_IN-1), which is exact.
  - o_neg = i_bin[W_IN-1], registered with o_bcd. Zero is never negative.
- Undefined: i_bin is unsigned, o_neg is tied to 0, and no negation logic is generated.

Decomposition:
- Shared display package holds:
  - State enum {IDLE, SHIFT, DONE}.
  - BCD_W=4 digit width.
  - The digit-adjust threshold constant (5) and offset (3).
  - A function computing the minimum N_DIG for a given W_IN, used for an elaboration-time warning.
- One sub-module, bcd_add3: 4-bit combinational digit adjust, instantiated N_DIG times via generate. The FSM and counter stay in the top.

Test Plan:
- W_IN=16, N_DIG=5, i_bin=12345, i_start pulse at edge 0 → o_done only in the cycle after edge 17, o_bcd=20'h12345, o_ovf=0, o_busy high for edges 0..16.
- i_bin=0 then i_bin=65535 back-to-back, i_start held high → results 20'h00000 then 20'h65535, second o_done 18 cycles after the first.
- With BIN2BCD_SIGNED_EN: i_bin=16'hFFFF → o_bcd=20'h00001, o_neg=1; i_bin=16'h8000 → 20'h32768, o_neg=1; i_bin=16'h7FFF → 20'h32767, o_neg=0.
- W_IN=8, N_DIG=2: i_bin=255 → o_bcd=8'h55, o_ovf=1; i_bin=99 → 8'h99, o_ovf=0.
- Start 1234 with a second i_start at cycle 5 carrying 9999 → exactly one o_done, o_bcd=20'h01234.
- Start a conversion, assert i_RST at cycle 8 for 2 cycles → all outputs 0 asynchronously and no o_done; the next start (42) gives 20'h00042 with normal latency.
